// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The fetch_entry_t field widths follow ADDR_W and INST_W below.
package fetch_pkg;

  localparam int ADDR_W = 11;
  localparam int INST_W = 32;

  // RISC-V canonical NOP (addi x0, x0, 0), shown to decode when nothing is queued.
  localparam logic [INST_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular store of fetched {pc, instr} entries with an occupancy count
// and a synchronous flush that empties the queue in one edge.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_en,
  input  fetch_entry_t wr_data,
  input  logic         rd_en,
  output fetch_entry_t rd_data,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: accepts PC addresses, issues single-cycle memory reads,
// and queues returned instructions in order for decode.
module instruction_fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int INST_W = fetch_pkg::INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_ready,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic              accept;
  logic              pop;
  logic              wr_en;
  logic              empty;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  assign id_valid = !empty;
  assign pop      = id_valid && id_ready;

  // Slots already promised: stored entries plus the read in flight, minus the one leaving now.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign pc_ready  = !rst && !flush && (occupancy < (CW+1)'(DEPTH));

  assign accept    = pc_valid && pc_ready;
  assign imem_rd   = accept;
  assign imem_addr = pc_addr;

  // Returned data is dropped if a flush lands in the same cycle it arrives.
  assign wr_en          = inflight_q && !flush;
  assign wr_entry.pc    = pend_addr_q;
  assign wr_entry.instr = imem_rdata;

  always_comb begin
    inflight_d  = accept;
    pend_addr_d = accept ? pc_addr : pend_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (pop && !flush),
    .rd_data (head),
    .count   (count),
    .empty   (empty)
  );

  assign id_instr = id_valid ? head.instr : NOP_INSTR;
  assign id_pc    = id_valid ? head.pc    : '0;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_instruction_fetch_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        pc_valid;
  logic [10:0] pc_addr;
  logic        pc_ready;
  logic        imem_rd;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [10:0] id_pc;

  instruction_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_valid   (pc_valid),
    .pc_addr    (pc_addr),
    .pc_ready   (pc_ready),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        model_q[$];
  bit          m_infl;
  logic [10:0] m_infl_addr;
  bit          resp_valid;
  logic [10:0] resp_addr;
  int          n_vec;
  int          n_err;

  // Instruction memory contents as a function of the byte address.
  function automatic logic [31:0] instr_of(input logic [10:0] a);
    return {a[7:0], ~a, 2'b10, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_id_valid"}, 64'(id_valid), 64'd0);
    check({tag, "_id_instr"}, 64'(id_instr), 64'(NOP));
    check({tag, "_id_pc"},    64'(id_pc),    64'd0);
    check({tag, "_pc_ready"}, 64'(pc_ready), 64'd0);
    check({tag, "_imem_rd"},  64'(imem_rd),  64'd0);
  endtask

  // One clock cycle: drive at the falling edge, compare #1 later, update the model at the rising edge.
  task automatic cycle(input logic v, input logic [10:0] a, input logic rdy, input logic fl);
    bit exp_valid, pop, exp_ready, acc;
    pc_valid   = v;
    pc_addr    = a;
    id_ready   = rdy;
    flush      = fl;
    imem_rdata = resp_valid ? instr_of(resp_addr) : $urandom;
    #1;
    exp_valid = (model_q.size() != 0);
    check("id_valid", 64'(id_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("id_pc",    64'(id_pc),    64'(model_q[0].pc));
      check("id_instr", 64'(id_instr), 64'(model_q[0].instr));
    end else begin
      check("id_pc_empty",    64'(id_pc),    64'd0);
      check("id_instr_empty", 64'(id_instr), 64'(NOP));
    end
    pop       = exp_valid && rdy;
    exp_ready = !fl && ((model_q.size() + int'(m_infl) - int'(pop)) < DEPTH);
    acc       = v && exp_ready;
    check("pc_ready", 64'(pc_ready), 64'(exp_ready));
    check("imem_rd",  64'(imem_rd),  64'(acc));
    if (acc) check("imem_addr", 64'(imem_addr), 64'(a));
    resp_valid = imem_rd;
    resp_addr  = imem_addr;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
      m_infl = 0;
    end else begin
      if (pop) void'(model_q.pop_front());
      if (m_infl) model_q.push_back('{pc: m_infl_addr, instr: instr_of(m_infl_addr)});
      m_infl      = acc;
      m_infl_addr = a;
    end
    @(negedge clk);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    m_infl     = 0;
    resp_valid = 0;
    resp_addr  = '0;
    rst        = 1'b1;
    pc_valid   = 1'b1;
    pc_addr    = 11'd0;
    id_ready   = 1'b1;
    flush      = 1'b0;
    imem_rdata = '0;
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Streaming fetch of 0,4,8 with decode always ready.
    cycle(1, 11'd0, 1, 0);
    cycle(1, 11'd4, 1, 0);
    cycle(1, 11'd8, 1, 0);
    repeat (3) cycle(0, 11'd0, 1, 0);

    // Back-pressure: decode stalled, queue fills, then drains in order.
    cycle(1, 11'd0, 0, 0);
    cycle(1, 11'd4, 0, 0);
    repeat (3) cycle(1, 11'd8, 0, 0);
    cycle(1, 11'd8, 1, 0);
    repeat (4) cycle(0, 11'd0, 1, 0);

    // Flush right after an accept discards the returning data.
    cycle(1, 11'd12, 1, 0);
    cycle(0, 11'd0, 1, 1);
    repeat (3) cycle(0, 11'd0, 1, 0);

    // Pop and flush in the same cycle: flush wins.
    cycle(1, 11'd0, 0, 0);
    cycle(1, 11'd4, 0, 0);
    cycle(0, 11'd0, 0, 0);
    cycle(0, 11'd0, 1, 1);
    cycle(0, 11'd0, 0, 0);

    // Asynchronous reset with a stored entry and a read in flight.
    cycle(1, 11'd0, 0, 0);
    cycle(1, 11'd4, 0, 0);
    pc_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    model_q.delete();
    m_infl     = 0;
    resp_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 11'd16, 1, 0);
    repeat (3) cycle(0, 11'd0, 1, 0);

    // Random traffic; unaligned addresses exercise the low-bit pass-through.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom % 4) != 0, 11'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
    end
    repeat (4) cycle(0, 11'd0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
